// File: rtl/mb_pkg.sv
// Shared Modbus RTU definitions: receive FSM states, CRC-16/Modbus constants and
// the silence-timing factor used by the frame receiver (and later the transmit framer).
package mb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2,
    HOLD  = 2'd3
  } mb_state_e;

  localparam logic [15:0] MB_CRC_INIT  = 16'hFFFF;
  localparam logic [15:0] MB_CRC_POLY  = 16'hA001;
  localparam logic [7:0]  MB_BROADCAST = 8'h00;

  // 3.5 characters of 11 bits each, rounded up to whole bit times
  localparam int unsigned MB_SIL_FACTOR = 39;

endpackage

// File: rtl/mb_crc16.sv
// Combinational CRC-16/Modbus byte update (reflected poly 0xA001), eight unrolled
// bit steps. Shared between the receive and transmit framers.
module mb_crc16
  import mb_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);

  logic [15:0] crc_acc;

  always_comb begin
    crc_acc = crc_in ^ {8'h00, byte_in};
    for (int i = 0; i < 8; i++) begin
      crc_acc = crc_acc[0] ? ((crc_acc >> 1) ^ MB_CRC_POLY) : (crc_acc >> 1);
    end
    crc_out = crc_acc;
  end

endmodule

// File: rtl/mb_frame_rx.sv
// Modbus RTU frame assembler: buffers UART bytes, ends frames on 3.5-char silence,
// checks length/CRC and holds good frames until acked. Optional MB_ADDR_FILTER_EN.
module mb_frame_rx
  import mb_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200,
  parameter int MAX_LEN  = 256,
  parameter int ADDR_W   = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic [7:0]        slave_addr,
  input  logic              frame_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [ADDR_W:0]   frame_len,
  output logic              byte_drop
);

  localparam int unsigned   SIL_CNT  = (CLK_FREQ / UART_BPS) * MB_SIL_FACTOR;
  localparam logic [23:0]   SIL_TERM = 24'(SIL_CNT - 1);
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(MAX_LEN);

  mb_state_e         state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [15:0]       crc_q, crc_d;
  logic              ovf_q, ovf_d;
  logic [23:0]       sil_q, sil_d;
  logic              frame_valid_q, frame_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              byte_drop_q, byte_drop_d;
  logic [ADDR_W:0]   frame_len_q, frame_len_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic [7:0]        mem [MAX_LEN];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       crc_src, crc_next;
  logic              go_idle;
  logic              addr_ok;

  // The first byte of a frame always starts a fresh CRC, whatever crc_q holds
  assign crc_src = (state_q == IDLE) ? MB_CRC_INIT : crc_q;

  mb_crc16 u_crc (
    .crc_in  (crc_src),
    .byte_in (byte_data),
    .crc_out (crc_next)
  );

`ifdef MB_ADDR_FILTER_EN
  logic [7:0] addr0_q, addr0_d;
  assign addr0_d = (state_q == IDLE && byte_valid) ? byte_data : addr0_q;
  assign addr_ok = (addr0_q == slave_addr) || (addr0_q == MB_BROADCAST);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr0_q <= 8'h00;
    else        addr0_q <= addr0_d;
  end
`else
  logic unused_slave_addr;
  assign unused_slave_addr = ^slave_addr;
  assign addr_ok = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    crc_d         = crc_q;
    ovf_d         = ovf_q;
    sil_d         = sil_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    byte_drop_d   = 1'b0;
    frame_len_d   = frame_len_q;
    rd_data_d     = mem[rd_addr];
    wr_en         = 1'b0;
    wr_addr       = len_q[ADDR_W-1:0];
    go_idle       = 1'b0;

    case (state_q)
      IDLE: begin
        if (byte_valid) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          len_d   = (ADDR_W + 1)'(1);
          crc_d   = crc_next;
          sil_d   = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (byte_valid) begin
          sil_d = '0;
          if (len_q < LEN_MAX) begin
            wr_en = 1'b1;
            len_d = len_q + (ADDR_W + 1)'(1);
            crc_d = crc_next;
          end else begin
            ovf_d       = 1'b1;
            byte_drop_d = 1'b1;
          end
        end else begin
          sil_d = (sil_q == '1) ? sil_q : sil_q + 24'd1;
          if (sil_d == SIL_TERM) state_d = CHECK;
        end
      end
      CHECK: begin
        byte_drop_d = byte_valid;
        if (len_q >= (ADDR_W + 1)'(4) && crc_q == 16'h0000 && !ovf_q) begin
          if (addr_ok) begin
            frame_len_d   = len_q - (ADDR_W + 1)'(2);
            frame_valid_d = 1'b1;
            state_d       = HOLD;
          end else begin
            go_idle = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
          go_idle     = 1'b1;
        end
      end
      HOLD: begin
        byte_drop_d = byte_valid;
        if (frame_ack) go_idle = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      state_d = IDLE;
      len_d   = '0;
      crc_d   = MB_CRC_INIT;
      ovf_d   = 1'b0;
      sil_d   = '0;
    end
  end

  // ---- registered control and outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      len_q         <= '0;
      crc_q         <= MB_CRC_INIT;
      ovf_q         <= 1'b0;
      sil_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      byte_drop_q   <= 1'b0;
      frame_len_q   <= '0;
      rd_data_q     <= 8'h00;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      crc_q         <= crc_d;
      ovf_q         <= ovf_d;
      sil_q         <= sil_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      byte_drop_q   <= byte_drop_d;
      frame_len_q   <= frame_len_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // ---- frame buffer, not reset ----
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= byte_data;
  end

  assign rd_data     = rd_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_len   = frame_len_q;
  assign byte_drop   = byte_drop_q;

endmodule

// File: tb/tb_mb_frame_rx.sv
// Randomized + directed bench for mb_frame_rx against a frame-level reference model.
module tb_mb_frame_rx;

  localparam int CLK_FREQ = 1152000;
  localparam int UART_BPS = 115200;
  localparam int MAX_LEN  = 32;
  localparam int ADDR_W   = $clog2(MAX_LEN);
  localparam int SIL_CNT  = (CLK_FREQ / UART_BPS) * 39;

  logic              clk;
  logic              rst_n;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic [7:0]        slave_addr;
  logic              frame_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              frame_valid;
  logic              frame_err;
  logic [ADDR_W:0]   frame_len;
  logic              byte_drop;

  mb_frame_rx #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS),
    .MAX_LEN  (MAX_LEN),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .slave_addr  (slave_addr),
    .frame_ack   (frame_ack),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .frame_len   (frame_len),
    .byte_drop   (byte_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Pulse monitor, sampled mid-cycle
  int ncyc = 0, last_bv = 0, fv_lat = 0, n_fv = 0, n_err = 0, n_drop = 0;
  always @(negedge clk) begin
    ncyc++;
    if (byte_valid) last_bv = ncyc;
    if (frame_valid) begin
      n_fv++;
      fv_lat = ncyc - last_bv;
    end
    if (frame_err) n_err++;
    if (byte_drop) n_drop++;
  end

  byte unsigned tx_q[$];

  function automatic logic [15:0] crc_of(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {8'h00, tx_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic make_frame(input int body, input int corrupt, input logic [7:0] addr);
    logic [15:0] c;
    int idx;
    tx_q.delete();
    tx_q.push_back(addr);
    for (int i = 1; i < body; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    c = crc_of(tx_q.size());
    tx_q.push_back(c[7:0]);
    tx_q.push_back(c[15:8]);
    if (corrupt != 0) begin
      idx = $urandom_range(0, tx_q.size() - 1);
      tx_q[idx] = tx_q[idx] ^ 8'($urandom_range(1, 255));
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic read_back(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rd_addr = ADDR_W'(i);
      @(posedge clk); #1;
      chk(tag, {24'h0, rd_data}, {24'h0, tx_q[i]});
    end
  endtask

  task automatic run_frame(input string tag, input int gap_after, input int gap_len, input int do_hold);
    int n, drops, good, silent, v0, e0, d0, d1;
    n      = tx_q.size();
    drops  = (n > MAX_LEN) ? n - MAX_LEN : 0;
    good   = (n >= 4 && n <= MAX_LEN && crc_of(n) == 16'h0000) ? 1 : 0;
    silent = 0;
`ifdef MB_ADDR_FILTER_EN
    if (good != 0 && tx_q[0] != slave_addr && tx_q[0] != 8'h00) begin
      good   = 0;
      silent = 1;
    end
`endif
    v0 = n_fv; e0 = n_err; d0 = n_drop;
    for (int i = 0; i < n; i++)
      send_byte(tx_q[i], (i == gap_after) ? gap_len : int'($urandom_range(1, 6)));
    repeat (SIL_CNT + 5) @(posedge clk);
    #1;
    chk({tag, "_valid"}, n_fv - v0, good);
    chk({tag, "_err"}, n_err - e0, (good == 0 && silent == 0) ? 1 : 0);
    chk({tag, "_drop"}, n_drop - d0, drops);
    if (good != 0) begin
      chk({tag, "_lat"}, fv_lat, SIL_CNT + 1);
      chk({tag, "_len"}, {26'h0, frame_len}, n - 2);
      read_back(n - 2, {tag, "_rd"});
    end
    if (good != 0 && do_hold != 0) begin
      d1 = n_drop;
      send_byte(8'hA5, 3);
      read_back(n - 2, {tag, "_hold_rd"});
      @(posedge clk); #1;
      frame_ack  = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'h5A;
      @(posedge clk); #1;
      frame_ack  = 1'b0;
      byte_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_hold_drop"}, n_drop - d1, 2);
    end else if (n_fv != v0) begin
      @(posedge clk); #1;
      frame_ack = 1'b1;
      @(posedge clk); #1;
      frame_ack = 1'b0;
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic load(input logic [63:0] bytes8);
    tx_q.delete();
    for (int i = 7; i >= 0; i--) tx_q.push_back(bytes8[i*8 +: 8]);
  endtask

  initial begin
    int v0, e0, r;
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    slave_addr = 8'h02;
    frame_ack  = 1'b0;
    rd_addr    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'h0, frame_valid}, 0);
    chk("rst_err", {31'h0, frame_err}, 0);
    chk("rst_drop", {31'h0, byte_drop}, 0);
    chk("rst_len", {26'h0, frame_len}, 0);
    chk("rst_rd", {24'h0, rd_data}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    load(64'h0103_0000_0001_840A);  run_frame("good", -1, 0, 0);
    load(64'h0103_0000_0001_840B);  run_frame("badcrc", -1, 0, 0);
    load(64'h0103_0000_0001_840A);  run_frame("gap30", 2, 300, 0);
    load(64'h0103_0000_0001_840A);  run_frame("gapmax", 4, SIL_CNT - 3, 0);
    tx_q.delete(); tx_q.push_back(8'h01); tx_q.push_back(8'h03); tx_q.push_back(8'h00);
    run_frame("short", -1, 0, 0);
    tx_q.delete();
    for (int i = 0; i < MAX_LEN + 1; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    run_frame("ovf", -1, 0, 0);
    load(64'h0003_0000_0001_85DB);  run_frame("hold", -1, 0, 1);
    load(64'h0103_0000_0001_840A);  run_frame("after_hold", -1, 0, 0);
    make_frame(MAX_LEN - 2, 0, 8'h02); run_frame("full", -1, 0, 0);

    // Reset in the middle of a frame must leave no trace
    v0 = n_fv; e0 = n_err;
    send_byte(8'h02, 2); send_byte(8'h03, 2); send_byte(8'h00, 2);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (SIL_CNT + 5) @(posedge clk);
    #1;
    chk("midrst_pulses", (n_fv - v0) + (n_err - e0), 0);
    load(64'h0003_0000_0001_85DB);  run_frame("post_rst", -1, 0, 0);

    for (int k = 0; k < 12; k++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        tx_q.delete();
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) tx_q.push_back(8'($urandom_range(0, 255)));
      end else if (r == 2) begin
        tx_q.delete();
        for (int i = 0; i < MAX_LEN + int'($urandom_range(1, 3)); i++) tx_q.push_back(8'($urandom_range(0, 255)));
      end else if (r < 5) begin
        make_frame($urandom_range(2, MAX_LEN - 2), 1, 8'($urandom_range(0, 3)));
      end else begin
        make_frame($urandom_range(2, MAX_LEN - 2), 0, 8'($urandom_range(0, 3)));
      end
      run_frame($sformatf("rnd%0d", k), -1, 0, int'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
